mem_port_arbiter: RTL

Single-port arbiter and boot sequencer for `mainMem`. Shares the one memory port among three requesters: the program loader (boot only), the data-memory stage (loads/stores from Execute), and the `fetch` stage. It holds the pipeline in BOOT until the loader finishes, then arbitrates each cycle. It routes read data back to the owner of each outstanding request and generates `fetch_stall`.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arb_tag_pipe.sv | 28 ++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the mainMem port arbiter: owner tags, sequencer states,
// and the fixed word access size used by the loader and fetch.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    DM   = 2'd1,
    IF   = 2'd2
  } tag_t;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [0:1] ACC_WORD = 2'b00;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; freezing holds
// every stage so pending tags resume where they left off.
module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic freeze,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= NONE;
    end else if (!freeze) begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Boot sequencer and single-port arbiter for mainMem: loader only in BOOT,
// then data-over-fetch priority with a starvation override for fetch.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int STARVE_MAX  = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ld_req,
  input  logic [0:31] ld_addr,
  input  logic [0:31] ld_wdata,
  input  logic        ld_done,
  output logic        ld_gnt,
  input  logic        dm_req,
  input  logic        dm_wren,
  input  logic [0:1]  dm_size,
  input  logic [0:31] dm_addr,
  input  logic [0:31] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [0:31] dm_rdata,
  input  logic        if_req,
  input  logic [0:31] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [0:31] if_rdata,
  output logic        fetch_stall,
  output logic        run,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_data_in,
  output logic [0:1]  mem_acc_size,
  output logic        mem_wren,
  output logic        mem_enable,
  input  logic [0:31] mem_data_out,
  input  logic        mem_busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [0:31]      last_addr;
  logic [0:31]      last_data;
  logic             starve_hit;
  tag_t             push_tag;
  tag_t             out_tag;

  always_comb begin
    ld_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_gnt     = 1'b0;
    starve_hit = (starve_cnt == CNT_W'(STARVE_MAX)) && if_req;
    if (state == BOOT) begin
      ld_gnt = ld_req && !mem_busy;
    end else if (!mem_busy) begin
      if (dm_req && !starve_hit) dm_gnt = 1'b1;
      else if (if_req)           if_gnt = 1'b1;
    end
  end

  // Idle cycles keep address/data at the last granted values.
  always_comb begin
    mem_enable   = ld_gnt || dm_gnt || if_gnt;
    mem_wren     = 1'b0;
    mem_acc_size = ACC_WORD;
    mem_addr     = last_addr;
    mem_data_in  = last_data;
    push_tag     = NONE;
    if (ld_gnt) begin
      mem_wren    = 1'b1;
      mem_addr    = ld_addr;
      mem_data_in = ld_wdata;
    end else if (dm_gnt) begin
      mem_wren     = dm_wren;
      mem_acc_size = dm_size;
      mem_addr     = dm_addr;
      mem_data_in  = dm_wdata;
      push_tag     = dm_wren ? NONE : DM;
    end else if (if_gnt) begin
      mem_addr = if_addr;
      push_tag = IF;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (mem_enable) begin
      last_addr <= mem_addr;
      last_data <= mem_data_in;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= BOOT;
      run        <= 1'b0;
      starve_cnt <= '0;
    end else if (state == BOOT) begin
      if (ld_done && !ld_gnt) begin
        state <= RUN;
        run   <= 1'b1;
      end
    end else begin
      if (!if_req || if_gnt)
        starve_cnt <= '0;
      else if (dm_gnt && starve_cnt != CNT_W'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  mem_arb_tag_pipe #(.DEPTH(MEM_LATENCY)) u_tag_pipe (
    .clock   (clock),
    .reset_n (reset_n),
    .freeze  (mem_busy),
    .tag_in  (push_tag),
    .tag_out (out_tag)
  );

  assign dm_rvalid   = !mem_busy && (out_tag == DM);
  assign if_rvalid   = !mem_busy && (out_tag == IF);
  assign dm_rdata    = dm_rvalid ? mem_data_out : '0;
  assign if_rdata    = if_rvalid ? mem_data_out : '0;
  assign fetch_stall = (state == BOOT) || (if_req && !if_gnt);

endmodule
